// File: rtl/muldiv_unit_pkg.sv
// Shared M-extension definitions: funct7/funct3 encodings, FSM states and
// operand-signedness helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: unsigned shift-add / restoring
// divide on operand magnitudes, with the result sign applied on completion.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_t         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q;
    logic [2:0]        f3_q;
    logic              sa_q, sb_q;
    logic              ready_q, busy_q, done_q;
    logic [XLEN-1:0]   fin_q, fin_d, result_q;

    logic              sa_d, sb_d, spec_hit;
    logic [XLEN-1:0]   mag_a, mag_b, spec_val;
    logic [XLEN:0]     mul_sum, div_rs;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, quo, rem;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        sa_d     = a_is_signed(funct3) & opA[XLEN-1];
        sb_d     = b_is_signed(funct3) & opB[XLEN-1];
        mag_a    = sa_d ? -opA : opA;
        mag_b    = sb_d ? -opB : opB;
        spec_hit = 1'b0;
        spec_val = '0;
        // Divide-by-zero and signed overflow finish without iterating.
        if (is_div(funct3)) begin
            if (opB == '0) begin
                spec_hit = 1'b1;
                spec_val = funct3[1] ? opA : '1;
            end else if (!funct3[0] && opA == {1'b1, {(XLEN-1){1'b0}}} && opB == '1) begin
                spec_hit = 1'b1;
                spec_val = funct3[1] ? '0 : opA;
            end
        end
    end

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        div_rs  = acc_q[2*XLEN-1:XLEN-1];
        div_ge  = div_rs >= {1'b0, dvs_q};
        div_rem = div_ge ? XLEN'(div_rs - {1'b0, dvs_q}) : div_rs[XLEN-1:0];
        // Divide shifts {rem, quo} left; multiply shifts {hi, multiplier} right.
        acc_d   = is_div(f3_q) ? {div_rem, acc_q[XLEN-2:0], div_ge}
                               : {mul_sum, acc_q[XLEN-1:1]};
        prod    = (sa_q ^ sb_q) ? -acc_d : acc_d;
        quo     = (sa_q ^ sb_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem     = sa_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                       fin_d = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_d = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_d = quo;
            default:                      fin_d = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fin_q    <= '0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !kill) begin
                        f3_q    <= funct3;
                        sa_q    <= sa_d;
                        sb_q    <= sb_d;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (spec_hit) begin
                            state_q <= S_DONE;
                            fin_q   <= spec_val;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            acc_q   <= {{XLEN{1'b0}}, is_div(funct3) ? mag_a : mag_b};
                            dvs_q   <= is_div(funct3) ? mag_b : mag_a;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= S_DONE;
                            fin_q   <= fin_d;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (!kill) result_q <= fin_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A flush during DONE suppresses the pulse and leaves the old result visible.
    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q & ~kill;
    assign result = done ? fin_q : result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage. It consumes funct3 from M-extension R-type instructions (funct7 = 0000001) and produces the arithmetic result that the single-cycle ALU cannot.
- Radix-2: one bit per cycle. Signed operands are converted to magnitudes, the core datapath is unsigned, and the result sign is fixed on completion.
- Handshake is start/done toward the hazard unit. The hazard unit stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width; internal product accumulator is 2*XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- kill  in  1  pipeline flush; aborts any operation in progress
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opA  in  XLEN  rs1 value
- opB  in  XLEN  rs2 value
- ready  out  1  high in IDLE
- busy  out  1  high in CALC or DONE
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  final value, held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low.
- Reset (rst=0 at a rising edge):
  - state goes to IDLE.
  - ready=1, busy=0, done=0, result=0; counter and accumulators are cleared.
  - Reset mid-operation discards the operation; no done pulse follows.
- States:
  - IDLE: on start=1 & kill=0, latch funct3, operand signs and magnitudes. Next state is DONE for special cases, otherwise CALC with count=0.
  - CALC: one iteration per cycle. At count=XLEN-1 the next state is DONE.
  - DONE: done=1 and result driven for one cycle. The next state is always IDLE, and start is not accepted in DONE.
- Start handling:
  - start while busy is ignored.
  - start and kill together in IDLE: start is ignored.
- kill=1 in CALC or DONE: next state is IDLE, done is suppressed (kill has priority), and result keeps its previous value.
- Latency: start high in cycle 0 gives done in cycle XLEN+1 (cycle 33 for XLEN=32). Special cases give done in cycle 1.
- Multiply:
  - Shift-add on |A|, |B|.
  - Signedness: MULH treats both operands as signed, MULHSU treats A as signed and B as unsigned, MULHU treats both as unsigned. MUL uses the low half, so signedness does not matter.
  - Negate the 2*XLEN product if sign(A) xor sign(B), considering only operands treated as signed.
  - MUL returns product[XLEN-1:0]; the others return product[2XLEN-1:XLEN].
- Divide:
  - Restoring, unsigned, on magnitudes (DIV/REM signed; DIVU/REMU unsigned).
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Special cases (decided in IDLE, no CALC):
  - Divide by zero (opB=0): DIV/DIVU give all ones; REM/REMU give opA.
  - Signed overflow (DIV/REM with opA=100..0 and opB=all ones): DIV gives opA, REM gives 0.
- No exceptions are raised. All arithmetic is modulo 2^XLEN or 2^(2XLEN); there are no X outputs after reset.

Decomposition:
- Add to the shared definitions header, alongside the existing opcode/funct3/funct7 macros:
  - the M-extension funct7 value 0000001;
  - the eight funct3 encodings (MUL…REMU);
  - the state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
- The AluControl decoder flags M-ops to route them here; no change to the aluControl width.
- Single module. The sign pre/post-processing is kept inline; no sub-module is warranted.

Test Plan:
- Reset, then MUL with opA=7, opB=0xFFFFFFFD, start pulsed one cycle → done exactly 33 cycles later, result=0xFFFFFFEB, busy high throughout, ready low.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done one cycle after start. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- MUL started, kill asserted in cycle 10 → ready next cycle, no done pulse, result unchanged. A second start pulsed in cycle 5 of an operation is ignored (exactly one done, value from the first op).
- rst=0 in cycle 20 of a DIV → state IDLE, all outputs at reset values the next cycle. A new op started afterwards completes correctly.
